// File: rtl/cache_types.sv
// Shared types and default geometry for the direct-mapped data cache.
package cache_types;
    localparam int S_INDEX_DFLT  = 3;
    localparam int S_OFFSET_DFLT = 5;
    localparam int tag_w         = 32 - S_INDEX_DFLT - S_OFFSET_DFLT;

    typedef logic [255:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESPOND
    } dc_state_t;
endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for one direct-mapped way: single read index,
// whole-line fill port and a byte-merge word write port.
module dcache_array
    import cache_types::*;
#(
    parameter  int S_INDEX  = S_INDEX_DFLT,
    parameter  int S_OFFSET = S_OFFSET_DFLT,
    localparam int TAG_W    = 32 - S_INDEX - S_OFFSET,
    localparam int SETS     = 2 ** S_INDEX,
    localparam int WORD_W   = S_OFFSET - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_INDEX-1:0] idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output line_t              rd_line,
    input  logic               line_we,
    input  logic [TAG_W-1:0]   line_tag,
    input  line_t              line_wdata,
    input  logic               byte_we,
    input  logic [WORD_W-1:0]  byte_word,
    input  logic [3:0]         byte_en,
    input  logic [31:0]        byte_wdata
);
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    line_t            data_q [SETS];
    logic [31:0]      old_word;
    logic [31:0]      merged_word;

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];
    assign old_word = rd_line[{byte_word, 5'b0} +: 32];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign merged_word[8*k +: 8] = byte_en[k] ? byte_wdata[8*k +: 8] : old_word[8*k +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_wdata;
        end else if (byte_we) begin
            data_q[idx][{byte_word, 5'b0} +: 32] <= merged_word;
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache: one word request at a
// time, answered by a single-cycle mem_resp, with line fill/evict over pmem.
module dcache_responder
    import cache_types::*;
#(
    parameter int S_INDEX  = S_INDEX_DFLT,
    parameter int S_OFFSET = S_OFFSET_DFLT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
    localparam int WORD_W = S_OFFSET - 2;

    dc_state_t state_q, state_d;

    logic [31:2]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              req_write;
    logic [TAG_W-1:0]  req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [WORD_W-1:0] req_word;

    logic               rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]   rd_tag;
    line_t              rd_line;
    logic               line_we, byte_we, rdata_we;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^mem_address[1:0];

    assign req_tag  = req_addr[31 -: TAG_W];
    assign req_idx  = req_addr[S_OFFSET +: S_INDEX];
    assign req_word = req_addr[2 +: WORD_W];
    assign hit      = rd_valid && (rd_tag == req_tag);

    dcache_array #(
        .S_INDEX  (S_INDEX),
        .S_OFFSET (S_OFFSET)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (req_idx),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .line_we    (line_we),
        .line_tag   (req_tag),
        .line_wdata (pmem_rdata),
        .byte_we    (byte_we),
        .byte_word  (req_word),
        .byte_en    (req_be),
        .byte_wdata (req_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request is captured only on acceptance; later initiator changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            req_write <= 1'b0;
        end else if (state_q == IDLE && (mem_read || mem_write)) begin
            req_addr  <= mem_address[31:2];
            req_wdata <= mem_wdata;
            req_be    <= mem_byte_enable;
            req_write <= mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           mem_rdata <= '0;
        else if (rdata_we) mem_rdata <= rd_line[{req_word, 5'b0} +: 32];
    end

    always_comb begin
        state_d      = state_q;
        line_we      = 1'b0;
        byte_we      = 1'b0;
        rdata_we     = 1'b0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    byte_we  = req_write;
                    rdata_we = !req_write;
                    state_d  = RESPOND;
                end else if (rd_valid && rd_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {rd_tag, req_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    line_we = 1'b1;
                    state_d = LOOKUP;
                end
            end
            RESPOND: begin
                mem_resp = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pmem_wdata = rd_line;
endmodule
